// File: rtl/mem_arbiter_n_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and index-width helper for the memory arbiter.
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arbiter_n_if.sv
// mem_arbiter_n_if: requester/memory bus of the arbiter; slave is the arbiter's view, master the environment's.
interface mem_arbiter_n_if import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PRIO_WIN = 3,
  localparam int IDX_W = idx_w(NUM_REQ),
  localparam int CNT_W = $clog2(PRIO_WIN + 1)
);
  logic flush;
  logic prio_boost;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0] req_rw;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0] resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic mem_req_valid;
  logic mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_req_rw;
  logic [DATA_W-1:0] mem_req_wdata;
  logic mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic busy;
  logic [IDX_W-1:0] grant_id;
  logic [CNT_W-1:0] prio_cnt;
  modport slave (
    input flush, prio_boost, req_valid, req_addr, req_rw, req_wdata,
          mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_addr,
           mem_req_rw, mem_req_wdata, busy, grant_id, prio_cnt
  );
  modport master (
    output flush, prio_boost, req_valid, req_addr, req_rw, req_wdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input req_ready, resp_valid, resp_rdata, mem_req_valid, mem_req_addr,
          mem_req_rw, mem_req_wdata, busy, grant_id, prio_cnt
  );
endinterface

// File: rtl/mem_arbiter_n_rr_pick.sv
// rr_pick: round-robin priority encoder; returns the first set request after i_ptr, wrapping.
module rr_pick import mem_arb_pkg::*; #(
  parameter int N = 2,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_j;
  assign o_any = |i_req;
  // Scan from farthest to nearest so the nearest set request is the last write.
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = W'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) o_idx = w_j;
    end
  end
endmodule

// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: round-robin arbiter of NUM_REQ requesters onto one memory port, one transaction in flight,
// with a D-cache priority window opened by prio_boost.
module mem_arbiter_n import mem_arb_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PRIO_IDX = 1,
  parameter int PRIO_WIN = 3,
  localparam int CNT_W = $clog2(PRIO_WIN + 1),
  localparam int IDX_W = idx_w(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  mem_arbiter_n_if.slave bus
);
  arb_state_e r_state, w_next_state;
  logic [CNT_W-1:0] r_prio_cnt, w_prio_next;
  logic [IDX_W-1:0] r_rr_ptr, r_grant_id, w_rr_idx, w_sel;
  logic w_idle, w_any, w_win, w_accept, w_req, w_resp;
  rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_rr (
    .i_req(bus.req_valid),
    .i_ptr(r_rr_ptr),
    .o_idx(w_rr_idx),
    .o_any(w_any)
  );
  assign w_idle = r_state == ARB_IDLE;
  assign w_win = (r_prio_cnt != '0) | bus.prio_boost;
  assign w_sel = (w_win & bus.req_valid[PRIO_IDX]) ? IDX_W'(PRIO_IDX) : w_rr_idx;
  assign w_accept = w_idle & w_any & bus.mem_req_ready;
  // Outputs are forced low while reset is held, even though they are combinational.
  assign w_req = rst_n & w_idle & w_any;
  assign w_resp = rst_n & ~w_idle & bus.mem_resp_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_prio_cnt <= '0;
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
      r_grant_id <= '0;
    end else begin
      r_state <= w_next_state;
      r_prio_cnt <= w_prio_next;
      if (w_accept) begin
        r_rr_ptr <= w_sel;
        r_grant_id <= w_sel;
      end
    end
  end
  always_comb begin
    w_next_state = w_accept ? ARB_BUSY : (!w_idle && bus.mem_resp_valid) ? ARB_IDLE : r_state;
    w_prio_next = bus.flush ? '0 :
                  bus.prio_boost ? CNT_W'(PRIO_WIN) :
                  (w_idle && r_prio_cnt != '0) ? r_prio_cnt - CNT_W'(1) : r_prio_cnt;
  end
  always_comb begin
    bus.mem_req_valid = w_req;
    bus.req_ready = (w_req & bus.mem_req_ready) ? NUM_REQ'(1) << w_sel : '0;
    bus.mem_req_addr = w_req ? bus.req_addr[w_sel*ADDR_W +: ADDR_W] : '0;
    bus.mem_req_rw = w_req & bus.req_rw[w_sel];
    bus.mem_req_wdata = w_req ? bus.req_wdata[w_sel*DATA_W +: DATA_W] : '0;
    bus.resp_valid = w_resp ? NUM_REQ'(1) << r_grant_id : '0;
    bus.resp_rdata = w_resp ? bus.mem_resp_rdata : '0;
  end
  assign bus.busy = r_state == ARB_BUSY;
  assign bus.grant_id = r_grant_id;
  assign bus.prio_cnt = r_prio_cnt;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb_mem_arbiter_n: directed bench for the 2- and 4-requester arbiters with a response scoreboard.
module tb_mem_arbiter_n;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  typedef struct {int owner; logic [15:0] data;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  mem_arbiter_n_if #(.NUM_REQ(2)) if2();
  mem_arbiter_n_if #(.NUM_REQ(4)) if4();
  mem_arbiter_n #(.NUM_REQ(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  mem_arbiter_n #(.NUM_REQ(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic resp_chk(input string tag, input logic [3:0] v, input logic [15:0] d);
    exp_t e;
    chk({tag, "_sbq"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_rvalid"}, v, 1 << e.owner);
    chk({tag, "_rdata"}, d, e.data);
  endtask
  task automatic txn2(input string tag, input logic [1:0] v, input int own, input logic [15:0] addr,
                      input logic rw, input logic [15:0] wd, input logic [15:0] rd);
    if2.req_valid = v;
    if2.mem_req_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, if2.req_ready, 1 << own);
    chk({tag, "_addr"}, if2.mem_req_addr, addr);
    chk({tag, "_rw"}, if2.mem_req_rw, rw);
    chk({tag, "_wdata"}, if2.mem_req_wdata, wd);
    sb.push_back(exp_t'{own, rd});
    tick();
    if2.req_valid = '0;
    if2.mem_req_ready = 1'b0;
    chk({tag, "_busy"}, if2.busy, 1);
    chk({tag, "_gid"}, if2.grant_id, own);
    chk({tag, "_mrv_busy"}, if2.mem_req_valid, 0);
    tick();
    if2.mem_resp_valid = 1'b1;
    if2.mem_resp_rdata = rd;
    #1;
    resp_chk(tag, 4'(if2.resp_valid), if2.resp_rdata);
    tick();
    if2.mem_resp_valid = 1'b0;
    chk({tag, "_idle"}, if2.busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    if2.flush = 0; if2.prio_boost = 0; if2.req_valid = '0; if2.req_rw = '0;
    if2.req_addr = {16'h0022, 16'h0011}; if2.req_wdata = '0;
    if2.mem_req_ready = 0; if2.mem_resp_valid = 0; if2.mem_resp_rdata = '0;
    if4.flush = 0; if4.prio_boost = 0; if4.req_valid = '0; if4.req_rw = '0;
    if4.req_addr = {16'h4003, 16'h4002, 16'h4001, 16'h4000}; if4.req_wdata = '0;
    if4.mem_req_ready = 0; if4.mem_resp_valid = 0; if4.mem_resp_rdata = '0;
    if2.req_valid = 2'b11;
    if2.mem_req_ready = 1'b1;
    #1;
    chk("rst_mrv", if2.mem_req_valid, 0);
    chk("rst_rdy", if2.req_ready, 0);
    chk("rst_addr", if2.mem_req_addr, 0);
    chk("rst_busy", if2.busy, 0);
    chk("rst_cnt", if2.prio_cnt, 0);
    chk("rst_gid", if2.grant_id, 0);
    chk("rst4_busy", if4.busy, 0);
    if2.req_valid = '0;
    if2.mem_req_ready = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    // reset asserted while a transaction is outstanding
    if2.req_valid = 2'b10;
    if2.mem_req_ready = 1'b1;
    #1;
    chk("mb_rdy", if2.req_ready, 2'b10);
    tick();
    if2.mem_req_ready = 1'b0;
    chk("mb_busy", if2.busy, 1);
    chk("mb_gid", if2.grant_id, 1);
    rst_n = 1'b0;
    if2.mem_resp_valid = 1'b1;
    if2.mem_resp_rdata = 16'hDEAD;
    #1;
    chk("mb_rst_busy", if2.busy, 0);
    chk("mb_rst_gid", if2.grant_id, 0);
    chk("mb_rst_rv", if2.resp_valid, 0);
    chk("mb_rst_rd", if2.resp_rdata, 0);
    chk("mb_rst_mrv", if2.mem_req_valid, 0);
    if2.mem_resp_valid = 1'b0;
    if2.req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", if2.prio_cnt, 0);
    txn2("lone", 2'b01, 0, 16'h0011, 0, 16'h0000, 16'h1111);
    txn2("pre", 2'b10, 1, 16'h0022, 0, 16'h0000, 16'h2222);
    // priority window: RR alone would pick requester 0 here
    if2.req_valid = 2'b11;
    if2.prio_boost = 1'b1;
    if2.mem_req_ready = 1'b1;
    #1;
    chk("win_rdy", if2.req_ready, 2'b10);
    chk("win_addr", if2.mem_req_addr, 16'h0022);
    sb.push_back(exp_t'{1, 16'h3333});
    tick();
    if2.prio_boost = 0; if2.mem_req_ready = 0; if2.req_valid = '0;
    chk("win_cnt3", if2.prio_cnt, 3);
    chk("win_busy", if2.busy, 1);
    tick();
    chk("win_frz", if2.prio_cnt, 3);
    if2.mem_resp_valid = 1'b1;
    if2.mem_resp_rdata = 16'h3333;
    #1;
    resp_chk("win", 4'(if2.resp_valid), if2.resp_rdata);
    tick();
    if2.mem_resp_valid = 1'b0;
    chk("win_idle", if2.busy, 0);
    chk("win_idle3", if2.prio_cnt, 3);
    tick();
    chk("win_cnt2", if2.prio_cnt, 2);
    if2.req_valid = 2'b11;
    #1;
    chk("win_hold_addr", if2.mem_req_addr, 16'h0022);
    chk("win_hold_rdy", if2.req_ready, 0);
    tick();
    chk("win_cnt1", if2.prio_cnt, 1);
    tick();
    chk("win_cnt0", if2.prio_cnt, 0);
    txn2("post", 2'b11, 0, 16'h0011, 0, 16'h0000, 16'h4444);
    // flush beats boost
    if2.prio_boost = 1'b1;
    tick();
    if2.prio_boost = 1'b0;
    chk("fb_cnt3", if2.prio_cnt, 3);
    if2.flush = 1'b1;
    if2.prio_boost = 1'b1;
    tick();
    if2.flush = 0; if2.prio_boost = 0;
    chk("fb_cnt0", if2.prio_cnt, 0);
    if2.req_addr = {16'h0022, 16'h1234};
    if2.req_valid = 2'b01;
    if2.mem_req_ready = 1'b1;
    #1;
    chk("fl_rdy", if2.req_ready, 2'b01);
    chk("fl_addr", if2.mem_req_addr, 16'h1234);
    sb.push_back(exp_t'{0, 16'hBEEF});
    tick();
    if2.req_valid = '0; if2.mem_req_ready = 0; if2.flush = 1'b1;
    tick();
    if2.flush = 1'b0;
    chk("fl_busy", if2.busy, 1);
    if2.mem_resp_valid = 1'b1;
    if2.mem_resp_rdata = 16'hBEEF;
    #1;
    resp_chk("fl", 4'(if2.resp_valid), if2.resp_rdata);
    tick();
    if2.mem_resp_valid = 1'b0;
    chk("fl_idle", if2.busy, 0);
    // backpressure
    if2.req_addr = {16'h0022, 16'h00A0};
    if2.req_valid = 2'b01;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("bp_mrv", if2.mem_req_valid, 1);
      chk("bp_addr", if2.mem_req_addr, 16'h00A0);
      chk("bp_rdy", if2.req_ready, 0);
      tick();
    end
    txn2("bp", 2'b01, 0, 16'h00A0, 0, 16'h0000, 16'h0BAD);
    // stray memory response while idle
    if2.mem_resp_valid = 1'b1;
    if2.mem_resp_rdata = 16'hFFFF;
    #1;
    chk("pe_rv", if2.resp_valid, 0);
    chk("pe_rd", if2.resp_rdata, 0);
    tick();
    if2.mem_resp_valid = 1'b0;
    chk("pe_busy", if2.busy, 0);
    if2.req_addr = {16'h0077, 16'h00A0};
    if2.req_rw = 2'b10;
    if2.req_wdata = {16'h5A5A, 16'h0000};
    txn2("wr", 2'b10, 1, 16'h0077, 1, 16'h5A5A, 16'h0000);
    // round-robin rotation across four requesters
    if4.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      int e;
      e = n % 4;
      if4.mem_req_ready = 1'b1;
      #1;
      chk("rr_rdy", if4.req_ready, 1 << e);
      chk("rr_addr", if4.mem_req_addr, 16'h4000 + e);
      sb.push_back(exp_t'{e, 16'(16'hA000 + n)});
      tick();
      if4.mem_req_ready = 1'b0;
      chk("rr_gid", if4.grant_id, e);
      tick();
      if4.mem_resp_valid = 1'b1;
      if4.mem_resp_rdata = 16'(16'hA000 + n);
      #1;
      resp_chk("rr", if4.resp_valid, if4.resp_rdata);
      tick();
      if4.mem_resp_valid = 1'b0;
      chk("rr_idle", if4.busy, 0);
    end
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
- Parametrised successor to the two-port I/D memory arbiter.
- Arbitrates NUM_REQ cache/DMA requesters onto a single main-memory port with one outstanding transaction.
- Selection is round-robin, except during a programmable priority window for one designated requester (D-cache), which opens when decode sees a memory instruction.
- The priority counter is now internal, and the grant is held until memory returns its response. Neither was true of the previous arbiter.

Parameters:
- NUM_REQ, 2: number of requesters (>=2).
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- PRIO_IDX, 1: index of the requester that wins during the priority window.
- PRIO_WIN, 3: window length in IDLE cycles (>=1). CNT_W = clog2(PRIO_WIN+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; clears the priority window.
- prio_boost  in  1  memory instruction in ID; (re)opens the window.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_rw  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- resp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- resp_rdata  out  DATA_W  read data, broadcast to all requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_rw  out  1  request read/write.
- mem_req_wdata  out  DATA_W  request write data.
- mem_resp_valid  in  1  memory completion (reads and writes).
- mem_resp_rdata  in  DATA_W  memory read data.
- busy  out  1  transaction outstanding.
- grant_id  out  clog2(NUM_REQ)  current or last owner.
- prio_cnt  out  CNT_W  window counter (debug/perf).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prio_cnt=0, rr_ptr=NUM_REQ-1, grant_id=0, busy=0. All outputs 0: req_ready, resp_valid, mem_req_valid, mem_req_addr/rw/wdata, resp_rdata.
- States:
  - IDLE -> BUSY on mem_req_valid & mem_req_ready.
  - BUSY -> IDLE on mem_resp_valid.
  - No other transitions.
- IDLE selection (combinational):
  - win = (prio_cnt!=0) | prio_boost.
  - If win & req_valid[PRIO_IDX], sel = PRIO_IDX.
  - Otherwise sel = first valid index searching from rr_ptr+1, wrapping modulo NUM_REQ.
- IDLE outputs:
  - mem_req_valid = |req_valid; it must not depend on mem_req_ready, so there is no combinational loop.
  - mem_req_addr/rw/wdata are muxed from sel.
  - req_ready[i] = (i==sel) & mem_req_ready & |req_valid.
- On acceptance:
  - Register grant_id = sel.
  - rr_ptr = sel, also when the grant came from the priority window.
  - Enter BUSY.
- BUSY:
  - mem_req_valid=0 and all req_ready=0.
  - On mem_resp_valid, resp_valid[grant_id]=1 for that same cycle (combinational pass-through) and resp_rdata=mem_resp_rdata.
  - resp_rdata is 0 whenever mem_resp_valid=0.
- Requesters hold valid/addr/rw/wdata stable until ready. A deasserted valid before ready is legal (the request is abandoned).
- prio_cnt next value, in priority order:
  - flush -> 0 (flush beats boost in the same cycle).
  - else prio_boost -> PRIO_WIN.
  - else IDLE & prio_cnt!=0 -> prio_cnt-1.
  - else hold. The counter freezes in BUSY.
- prio_boost takes effect in the same cycle (via win) and reloads on every assertion; it does not saturate beyond PRIO_WIN.
- flush does not abort an outstanding transaction; the response is still delivered.
- mem_resp_valid in IDLE is a protocol error and is ignored: no resp_valid, no state change.
- Reset mid-BUSY drops the outstanding transaction; memory must be reset together with the arbiter.
- Throughput: at most one transaction per (accept cycle + memory latency + 1 IDLE cycle).

Decomposition:
- Shared package mem_arb_pkg:
  - state enum ARB_IDLE/ARB_BUSY.
  - Default width constants ADDR_W_DEF=16 and DATA_W_DEF=16.
  - Index-width helper function.
- Sub-module rr_pick:
  - Parametrised round-robin priority encoder.
  - Inputs: req vector, pointer.
  - Outputs: index, any.
  - Instantiated once.

Test Plan:
- Reset behaviour: hold rst_n=0 mid-BUSY, with NUM_REQ=2 -> all outputs 0 asynchronously. After release: busy=0, prio_cnt=0, and a lone req_valid=2'b01 is granted to requester 0.
- Round-robin rotation: NUM_REQ=4, all requesters continuously valid, memory latency 2 -> grant order 0,1,2,3,0. Each resp_valid is one-hot to the matching owner.
- Priority window: NUM_REQ=2, both valid, rr_ptr=1, prio_boost pulsed 1 cycle -> requester 1 wins (window, not RR). prio_cnt=3, then 2 and 1 across IDLE cycles, frozen in BUSY. After the window expires, requester 0 wins.
- Flush/boost collision: flush=1 and prio_boost=1 in the same cycle -> prio_cnt=0 next cycle. Flush in BUSY with addr 0x1234 read outstanding -> response 0xBEEF still delivered to its owner.
- Backpressure: mem_req_ready=0 for 5 cycles with requester 0 valid, addr 0x00A0 -> mem_req_valid=1 and addr stable throughout, req_ready=0. Accepted on the first ready cycle.
- Protocol error: mem_resp_valid pulsed in IDLE -> no resp_valid, state stays IDLE. A write (rw=1, wdata 0x5A5A) completes via its ack and returns to IDLE.
